// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : ALU opcode encoding shared by the decoder and execute stage |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 3'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 3'd7;

endpackage
`default_nettype wire

// File: rtl/alu_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_skid_buf : 2-entry registered output buffer with flush            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module alu_skid_buf #(
    parameter int DW = 38
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_data,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [DW-1:0] pop_data
);

    logic [DW-1:0] head_r;
    logic [DW-1:0] skid_r;
    logic [1:0]    count_r;
    logic [1:0]    count_nxt;
    logic          ready_r;
    logic          push;
    logic          pop;

    assign push       = push_valid && ready_r;
    assign pop        = (count_r != 2'd0) && pop_ready;
    assign push_ready = ready_r;
    assign pop_valid  = (count_r != 2'd0);
    assign pop_data   = head_r;

    always_comb begin
        count_nxt = count_r;
        if (push && !pop)
            count_nxt = count_r + 2'd1;
        else if (pop && !push)
            count_nxt = count_r - 2'd1;
    end

    // ready is registered from the next count so out_ready never reaches in_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            skid_r  <= '0;
            count_r <= 2'd0;
            ready_r <= 1'b1;
        end else if (flush) begin
            count_r <= 2'd0;
            ready_r <= 1'b1;
        end else begin
            if (push && ((count_r == 2'd0) || ((count_r == 2'd1) && pop)))
                head_r <= push_data;
            else if (pop && (count_r == 2'd2))
                head_r <= skid_r;
            if (push && (count_r == 2'd1) && !pop)
                skid_r <= push_data;
            count_r <= count_nxt;
            ready_r <= (count_nxt != 2'd2);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_ex_stage : execute-stage ALU with skid-buffered registered output |
// | Option: ALU_ZERO_FLAG_EN adds out_zero.   Revision: 1.0               |
// +----------------------------------------------------------------------+
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic [TAG_W-1:0]    out_tag
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic                out_zero
`endif
);

`ifdef ALU_ZERO_FLAG_EN
    localparam int DW = WIDTH + TAG_W + 1;
`else
    localparam int DW = WIDTH + TAG_W;
`endif

    logic [WIDTH-1:0] result;
    logic [DW-1:0]    push_data;
    logic [DW-1:0]    pop_data;

    always_comb begin
        result = '0;
        case (in_op)
            ALU_AND:  result = in_a & in_b;
            ALU_OR:   result = in_a | in_b;
            ALU_XOR:  result = in_a ^ in_b;
            ALU_NOR:  result = ~(in_a | in_b);
            ALU_ADD:  result = in_a + in_b;
            ALU_SUB:  result = in_a - in_b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            default:  result = '0;
        endcase
    end

`ifdef ALU_ZERO_FLAG_EN
    assign push_data = {(result == '0), in_tag, result};
    assign out_zero  = pop_data[DW-1];
`else
    assign push_data = {in_tag, result};
`endif

    assign out_result = pop_data[WIDTH-1:0];
    assign out_tag    = pop_data[WIDTH +: TAG_W];

    alu_skid_buf #(
        .DW (DW)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (push_data),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (pop_data)
    );

endmodule
`default_nettype wire
